calc_cmd_issuer: RTL and testbench
==================================

// Module: calc_cmd_issuer
// PURPOSE
//  Front end that produces the 3-bit funct stream consumed by the calculator control logic.
//  Accepts operator key events (op, chain flag, operand), encodes them to funct, and issues
//  one command at a time. Multiply/divide commands stall until the multiplier reports done.
//  Sits between keypad/host input and the control LUT + datapath.
// PARAMETERS
//  WIDTH     8    operand width, bits
//  TIMEOUT   64   max cycles to wait for mult_done before aborting, >=2
// PORTS
//  clk          in   1      system clock, rising edge
//  reset        in   1      synchronous, active-high
//  key_valid    in   1      key event present
//  key_ready    out  1      issuer can accept a key this cycle
//  key_op       in   2      0=add 1=sub 2=mult 3=div
//  key_chain    in   1      1 = operate on previous result (…ToPrev / …WithPrev forms)
//  key_operand  in   WIDTH  operand carried with the key
//  funct        out  3      encoded opcode to control logic
//  operand_out  out  WIDTH  operand aligned with funct
//  cmd_valid    out  1      one-cycle pulse: funct/operand_out are a new command
//  start_mult   out  1      one-cycle pulse with cmd_valid for mult/div commands
//  mult_done    in   1      multiplier/divider finished (level or pulse, sampled each cycle)
//  busy         out  1      FSM not IDLE
//  err          out  1      one-cycle pulse: key rejected or timeout
// BEHAVIOUR
//  Encoding: add 000/100, sub 001/101, mult 010/110, div 111/011 (no-chain/chain).
//  Reset: funct=000, operand_out=0, cmd_valid=0, start_mult=0, busy=0, err=0, has_prev=0,
//   pending slot empty, FSM=IDLE, timeout counter=0. Reset mid-wait aborts; no err pulse.
//  Acceptance: key taken when key_valid & key_ready at a rising edge. key_ready = !pend_full.
//  One-entry pending slot; a key accepted while busy waits there (no loss, strict order).
//  FSM states: IDLE, ISSUE, WAIT_DONE.
//   IDLE: slot full -> ISSUE (slot consumed). Key accepted in IDLE with slot empty bypasses
//    the slot: cmd_valid asserted the cycle after acceptance (latency 1).
//   ISSUE: registers funct/operand_out, pulses cmd_valid; start_mult too for mult/div.
//    add/sub -> IDLE next cycle; mult/div -> WAIT_DONE with counter cleared.
//   WAIT_DONE: mult_done -> IDLE; counter reaches TIMEOUT-1 without done -> err pulse, IDLE.
//    mult_done and timeout in the same cycle: done wins, no err.
//  mult_done outside WAIT_DONE is ignored.
//  has_prev set when any command completes (add/sub at issue, mult/div at done); cleared
//   only by reset. Chain key with has_prev=0 -> key consumed, not issued, err pulse 1 cycle.
//   Check uses has_prev at issue time, so a chain key queued behind the first command is legal.
//  funct/operand_out hold last issued value between commands.
//  Back-to-back add/sub: max throughput one command per 2 cycles.
// CONFIGURATION
//  CALC_DIV_EN defined: key_op=3 encodes to 111/011, handled as mult-class (start_mult, waits).
//  CALC_DIV_EN undefined: key_op=3 consumed, never issued, err pulse; funct never 111/011.
// TESTING
//  T1 reset, key add/no-chain operand 8'h05 -> next cycle funct=000, operand_out=05,
//     cmd_valid=1, start_mult=0; busy low two cycles later.
//  T2 chain sub (op=1,chain=1) first after reset -> err 1 cycle, no cmd_valid, has_prev stays 0.
//  T3 mult operand 8'h03, mult_done after 10 cycles -> funct=010, start_mult 1 cycle,
//     busy high 10 cycles; add key during wait parked (key_ready=0 after), issued after done.
//  T4 mult with mult_done never asserted, TIMEOUT=64 -> err pulse exactly 64 cycles after
//     entering WAIT_DONE, FSM IDLE, next key issues normally.
//  T5 div chain (op=3,chain=1) after one add: with CALC_DIV_EN funct=011 + start_mult;
//     without it err pulse, no command.
//  T6 reset asserted during WAIT_DONE with slot full -> all outputs reset values next cycle,
//     queued key dropped, mult_done one cycle later ignored.

Source files
------------

// File: rtl/calc_cmd_issuer.sv
// calc_cmd_issuer: keypad/host front end for the calculator control logic.
// Encodes operator key events into the 3-bit funct stream and issues one command
// at a time. Multiply/divide commands hold the issuer until mult_done, with a
// timeout after TIMEOUT cycles. A one-entry pending slot keeps keys arriving
// while busy in strict order.
// Optional feature macro: CALC_DIV_EN. When defined, key_op=3 (divide) is issued
// as a mult-class command. When undefined, divide keys are consumed and flagged
// with err.
module calc_cmd_issuer #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [1:0]       key_op,
  input  logic             key_chain,
  input  logic [WIDTH-1:0] key_operand,
  output logic [2:0]       funct,
  output logic [WIDTH-1:0] operand_out,
  output logic             cmd_valid,
  output logic             start_mult,
  input  logic             mult_done,
  output logic             busy,
  output logic             err
);

`ifdef CALC_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  localparam int            CntW    = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } issuerState;

  issuerState       state;
  logic             pendFull;
  logic [1:0]       pendOp;
  logic             pendChain;
  logic [WIDTH-1:0] pendOperand;
  logic             hasPrev;
  logic [CntW-1:0]  waitCnt;

  logic             keyAccept;
  logic             dispatch;
  logic [1:0]       selOp;
  logic             selChain;
  logic [WIDTH-1:0] selOperand;
  logic [2:0]       selFunct;
  logic             selLegal;

  // Map an operator key to its funct code; divide swaps the chain polarity.
  function automatic logic [2:0] encodeOp(input logic [1:0] op, input logic chain);
    logic [2:0] code;
    unique case (op)
      2'd0:    code = {chain, 2'b00};
      2'd1:    code = {chain, 2'b01};
      2'd2:    code = {chain, 2'b10};
      default: code = {~chain, 2'b11};
    endcase
    return code;
  endfunction

  assign key_ready = !pendFull;
  assign keyAccept = key_valid && key_ready;
  assign busy      = (state != IDLE);
  // In IDLE a key is dispatched from the slot if one is parked, otherwise straight
  // from the input (bypass); the slot can only be empty when a key is accepted here.
  assign dispatch  = (state == IDLE) && (pendFull || keyAccept);

  // Select the key being dispatched and decide whether it may be issued.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned; a missing default would infer a latch.
    selOp      = key_op;
    selChain   = key_chain;
    selOperand = key_operand;
    if (pendFull) begin
      selOp      = pendOp;
      selChain   = pendChain;
      selOperand = pendOperand;
    end
    selFunct = encodeOp(selOp, selChain);
    // Legality uses hasPrev as it stands when the key is dispatched, so a chain key
    // parked behind the first command sees that command's completion.
    selLegal = !(selChain && !hasPrev) && ((selOp != 2'd3) || DivEn);
  end

  // Pending slot payload: captured when a key arrives while the FSM is busy.
  always_ff @(posedge clk) begin
    // NOTE: the payload has no reset; pendFull alone says whether it is meaningful,
    // so clearing the data would only add reset fan-out.
    if (keyAccept && (state != IDLE)) begin
      pendOp      <= key_op;
      pendChain   <= key_chain;
      pendOperand <= key_operand;
    end
  end

  // Issue FSM with registered command outputs, slot occupancy and wait timer.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register in
    // this block sees the pre-edge values, independent of statement order.
    if (reset) begin
      state       <= IDLE;
      funct       <= 3'b000;
      operand_out <= '0;
      cmd_valid   <= 1'b0;
      start_mult  <= 1'b0;
      err         <= 1'b0;
      pendFull    <= 1'b0;
      hasPrev     <= 1'b0;
      waitCnt     <= '0;
    end else begin
      cmd_valid  <= 1'b0;
      start_mult <= 1'b0;
      err        <= 1'b0;

      if (keyAccept && (state != IDLE)) begin
        pendFull <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (dispatch) begin
            pendFull <= 1'b0;
            if (selLegal) begin
              funct       <= selFunct;
              operand_out <= selOperand;
              cmd_valid   <= 1'b1;
              // funct[1] is set exactly for mult and div codes.
              start_mult  <= selFunct[1];
              state       <= ISSUE;
            end else begin
              err <= 1'b1;
            end
          end
        end

        ISSUE: begin
          if (funct[1]) begin
            waitCnt <= '0;
            state   <= WAIT_DONE;
          end else begin
            hasPrev <= 1'b1;
            state   <= IDLE;
          end
        end

        WAIT_DONE: begin
          // A done arriving on the timeout cycle still completes the command.
          if (mult_done) begin
            hasPrev <= 1'b1;
            state   <= IDLE;
          end else if (waitCnt == CntLast) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_cmd_issuer.sv
// Directed bench for calc_cmd_issuer (WIDTH=8, TIMEOUT=64). Expected commands are
// queued when a key is driven and compared whenever the DUT pulses cmd_valid.
module tb_calc_cmd_issuer;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             key_valid;
  logic             key_ready;
  logic [1:0]       key_op;
  logic             key_chain;
  logic [WIDTH-1:0] key_operand;
  logic [2:0]       funct;
  logic [WIDTH-1:0] operand_out;
  logic             cmd_valid;
  logic             start_mult;
  logic             mult_done;
  logic             busy;
  logic             err;

  calc_cmd_issuer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_op      (key_op),
    .key_chain   (key_chain),
    .key_operand (key_operand),
    .funct       (funct),
    .operand_out (operand_out),
    .cmd_valid   (cmd_valid),
    .start_mult  (start_mult),
    .mult_done   (mult_done),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]       f;
    logic [WIDTH-1:0] o;
    logic             s;
  } cmdT;

  cmdT sb[$];
  int  asserts   = 0;
  int  fails     = 0;
  int  cycle     = 0;
  int  errPulses = 0;
  int  lastCmdCycle = 0;
  int  prevCmdCycle = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expectCmd(input logic [2:0] f, input logic [WIDTH-1:0] o, input logic s);
    cmdT c;
    c.f = f;
    c.o = o;
    c.s = s;
    sb.push_back(c);
  endtask

  // One clock: sample #1 after the edge and score any command the DUT issued.
  task automatic tick();
    cmdT c;
    @(posedge clk);
    #1;
    cycle++;
    if (err === 1'b1) errPulses++;
    if (cmd_valid === 1'b1) begin
      prevCmdCycle = lastCmdCycle;
      lastCmdCycle = cycle;
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        c = sb.pop_front();
        check("cmd_funct", 32'(funct), 32'(c.f));
        check("cmd_operand", 32'(operand_out), 32'(c.o));
        check("cmd_start_mult", 32'(start_mult), 32'(c.s));
      end
    end else begin
      check("start_without_cmd", 32'(start_mult), 32'd0);
    end
  endtask

  // Present a key until the DUT can take it, then hold it for the accepting edge.
  task automatic sendKey(input logic [1:0] op, input logic chain, input logic [WIDTH-1:0] opnd);
    int guard;
    guard       = 0;
    key_valid   = 1'b1;
    key_op      = op;
    key_chain   = chain;
    key_operand = opnd;
    while (key_ready !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    check("key_ready_wait_bound", 32'(guard < 200), 32'd1);
    tick();
    key_valid = 1'b0;
  endtask

  task automatic applyReset();
    reset     = 1'b1;
    key_valid = 1'b0;
    mult_done = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  initial begin
    int run;
    int n;
    int e0;

    key_op      = 2'd0;
    key_chain   = 1'b0;
    key_operand = '0;
    applyReset();

    // Reset state
    check("rst_funct", 32'(funct), 32'd0);
    check("rst_operand", 32'(operand_out), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_start_mult", 32'(start_mult), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_key_ready", 32'(key_ready), 32'd1);

    // T2: chain key with no previous result is rejected
    e0 = errPulses;
    sendKey(2'd1, 1'b1, 8'h11);
    check("t2_err", 32'(err), 32'd1);
    check("t2_no_cmd", 32'(cmd_valid), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);
    tick();
    check("t2_err_one_cycle", 32'(err), 32'd0);
    check("t2_err_count", 32'(errPulses - e0), 32'd1);

    // T1: plain add, latency 1, busy drops two cycles after the key
    applyReset();
    expectCmd(3'b000, 8'h05, 1'b0);
    sendKey(2'd0, 1'b0, 8'h05);
    check("t1_cmd_valid", 32'(cmd_valid), 32'd1);
    check("t1_busy_issue", 32'(busy), 32'd1);
    tick();
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_pulse_one_cycle", 32'(cmd_valid), 32'd0);
    check("t1_funct_hold", 32'(funct), 32'd0);
    check("t1_operand_hold", 32'(operand_out), 32'h05);

    // A chain key parked behind the first command after reset is legal
    applyReset();
    expectCmd(3'b000, 8'h01, 1'b0);
    expectCmd(3'b100, 8'h02, 1'b0);
    sendKey(2'd0, 1'b0, 8'h01);
    sendKey(2'd0, 1'b1, 8'h02);
    repeat (3) tick();
    check("queued_chain_no_err", 32'(errPulses - e0), 32'd1);

    // Back-to-back add/sub: one command every two cycles
    expectCmd(3'b000, 8'h21, 1'b0);
    expectCmd(3'b001, 8'h22, 1'b0);
    sendKey(2'd0, 1'b0, 8'h21);
    sendKey(2'd1, 1'b0, 8'h22);
    repeat (3) tick();
    check("b2b_gap", 32'(lastCmdCycle - prevCmdCycle), 32'd2);

    // T3: mult with done after 10 busy cycles, add parked during the wait
    e0 = errPulses;
    expectCmd(3'b010, 8'h03, 1'b1);
    expectCmd(3'b000, 8'h07, 1'b0);
    sendKey(2'd2, 1'b0, 8'h03);
    check("t3_start_mult", 32'(start_mult), 32'd1);
    run = 1;
    sendKey(2'd0, 1'b0, 8'h07);
    check("t3_slot_full", 32'(key_ready), 32'd0);
    run += int'(busy);
    n = 0;
    while (run < 10 && n < 50) begin
      tick();
      run += int'(busy);
      n++;
    end
    check("t3_busy_run", 32'(run), 32'd10);
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    check("t3_done_idle", 32'(busy), 32'd0);
    tick();
    check("t3_parked_issued", 32'(cmd_valid), 32'd1);
    tick();
    check("t3_ready_again", 32'(key_ready), 32'd1);
    check("t3_no_err", 32'(errPulses - e0), 32'd0);

    // T4: mult never completes, timeout err 64 cycles after entering the wait
    e0 = errPulses;
    expectCmd(3'b010, 8'h09, 1'b1);
    sendKey(2'd2, 1'b0, 8'h09);
    tick();
    n = 0;
    while (err !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("t4_timeout_cycles", 32'(n), 32'(TIMEOUT));
    check("t4_idle_after_timeout", 32'(busy), 32'd0);
    check("t4_err_count", 32'(errPulses - e0), 32'd1);
    expectCmd(3'b000, 8'h0A, 1'b0);
    sendKey(2'd0, 1'b0, 8'h0A);
    check("t4_next_issues", 32'(cmd_valid), 32'd1);
    tick();

    // Done on the final timeout cycle wins: no err
    e0 = errPulses;
    expectCmd(3'b010, 8'h0B, 1'b1);
    sendKey(2'd2, 1'b0, 8'h0B);
    tick();
    repeat (TIMEOUT - 1) tick();
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    check("done_vs_timeout_err", 32'(err), 32'd0);
    check("done_vs_timeout_idle", 32'(busy), 32'd0);

    // mult_done while idle is ignored
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    tick();
    check("stray_done_busy", 32'(busy), 32'd0);
    check("stray_done_err", 32'(errPulses - e0), 32'd0);

    // T5: chain divide after previous results
`ifdef CALC_DIV_EN
    expectCmd(3'b011, 8'h44, 1'b1);
    sendKey(2'd3, 1'b1, 8'h44);
    check("t5_div_issue", 32'(cmd_valid), 32'd1);
    repeat (3) tick();
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    check("t5_div_done", 32'(busy), 32'd0);
    expectCmd(3'b111, 8'h45, 1'b1);
    sendKey(2'd3, 1'b0, 8'h45);
    tick();
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    check("t5_div_nochain_done", 32'(busy), 32'd0);
    check("t5_no_err", 32'(errPulses - e0), 32'd0);
`else
    sendKey(2'd3, 1'b1, 8'h44);
    check("t5_div_err", 32'(err), 32'd1);
    check("t5_div_no_cmd", 32'(busy), 32'd0);
    check("t5_funct_hold", 32'(funct), 32'b010);
    check("t5_operand_hold", 32'(operand_out), 32'h0B);
    sendKey(2'd3, 1'b0, 8'h45);
    check("t5_div_nochain_err", 32'(err), 32'd1);
    tick();
    check("t5_err_count", 32'(errPulses - e0), 32'd2);
`endif

    // T6: reset during the wait with the slot full drops everything
    expectCmd(3'b110, 8'h0C, 1'b1);
    sendKey(2'd2, 1'b1, 8'h0C);
    sendKey(2'd0, 1'b0, 8'h0D);
    check("t6_slot_full", 32'(key_ready), 32'd0);
    reset = 1'b1;
    tick();
    check("t6_rst_funct", 32'(funct), 32'd0);
    check("t6_rst_operand", 32'(operand_out), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ready", 32'(key_ready), 32'd1);
    check("t6_rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    check("t6_done_ignored", 32'(busy), 32'd0);
    check("t6_no_cmd", 32'(cmd_valid), 32'd0);
    tick();
    check("t6_dropped_key", 32'(cmd_valid), 32'd0);
    check("t6_no_err", 32'(err), 32'd0);
    sendKey(2'd0, 1'b1, 8'h0E);
    check("t6_has_prev_cleared", 32'(err), 32'd1);
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
